// File: rtl/cc_unit_pkg.sv
// Shared LC-3b datapath types used by the condition-code logic.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;

  localparam lc3b_nzp CC_RESET = 3'b010;

endpackage

// File: rtl/cc_unit_gencc.sv
// Combinational NZP generator: exactly one of n/z/p is set for any word.
module gencc
  import lc3b_types::*;
(
  input  lc3b_word data_i,
  output lc3b_nzp  nzp_o
);

  logic n;
  logic z;

  assign n     = data_i[15];
  assign z     = (data_i == 16'h0000);
  assign nzp_o = {n, z, ~n & ~z};

endmodule

// File: rtl/cc_unit.sv
// Condition-code unit: CC register, in-flight CC-writer tracking, branch stall and bypass.
module cc_unit
  import lc3b_types::*;
#(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cc_claim,
  input  logic             load_cc,
  input  lc3b_word         wb_data,
  input  logic             flush,
  input  logic [CNT_W-1:0] flush_squash,
  input  logic             br_req,
  output lc3b_nzp          cc_out,
  output lc3b_nzp          cc_fwd,
  output logic             cc_ready,
  output logic             br_stall,
  output logic [CNT_W-1:0] pending,
  output logic             cc_err
);

  // Two extra bits give headroom for both overshoot and a sign.
  localparam int CW = CNT_W + 2;
  localparam logic signed [CW-1:0] MAX_S  = CW'(MAX_PENDING);
  localparam logic signed [CW-1:0] ZERO_S = '0;

  lc3b_nzp          ccGen;
  lc3b_nzp          cc_q, cc_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             err_q, err_d;

  logic signed [CW-1:0] afterClaim, afterLoad, afterFlush, squashExt;
  logic                 claimOvf, loadUnf, squashErr;

  gencc u_gencc (
    .data_i (wb_data),
    .nzp_o  (ccGen)
  );

  // A claim in a flush cycle belongs to a squashed instruction and is dropped.
  always_comb begin
    afterClaim = {2'b00, pending_q} + {{(CW-1){1'b0}}, cc_claim & ~flush};
    afterLoad  = afterClaim - {{(CW-1){1'b0}}, load_cc};
    squashExt  = {2'b00, flush_squash};
    afterFlush = flush ? (afterLoad - squashExt) : afterLoad;

    claimOvf  = (afterClaim > MAX_S);
    loadUnf   = (afterLoad < ZERO_S);
    squashErr = flush & (afterLoad >= ZERO_S) & (squashExt > afterLoad);

    pending_d = afterFlush[CNT_W-1:0];
    if (afterFlush < ZERO_S) begin
      pending_d = '0;
    end else if (afterFlush > MAX_S) begin
      pending_d = MAX_S[CNT_W-1:0];
    end

    err_d = err_q | claimOvf | loadUnf | squashErr;
    cc_d  = load_cc ? ccGen : cc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q      <= CC_RESET;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cc_q      <= cc_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // The last outstanding writer retiring this cycle resolves CC via the bypass.
  assign cc_ready = (pending_q == '0) | ((pending_q == CNT_W'(1)) & load_cc);
  assign br_stall = br_req & ~cc_ready;
  assign cc_fwd   = load_cc ? ccGen : cc_q;
  assign cc_out   = cc_q;
  assign pending  = pending_q;
  assign cc_err   = err_q;

endmodule

// File: tb/tb_cc_unit.sv
// Scoreboard bench for cc_unit: directed vectors push expected outputs, a monitor compares them.
module tb_cc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cc_claim;
  logic        load_cc;
  logic [15:0] wb_data;
  logic        flush;
  logic [1:0]  flush_squash;
  logic        br_req;
  logic [2:0]  cc_out;
  logic [2:0]  cc_fwd;
  logic        cc_ready;
  logic        br_stall;
  logic [1:0]  pending;
  logic        cc_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         chk;
    int         idx;
    logic [2:0] out;
    logic [2:0] fwd;
    logic       rdy;
    logic       stall;
    logic [1:0] pend;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   vecNum = 0;

  cc_unit #(.MAX_PENDING(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .cc_claim     (cc_claim),
    .load_cc      (load_cc),
    .wb_data      (wb_data),
    .flush        (flush),
    .flush_squash (flush_squash),
    .br_req       (br_req),
    .cc_out       (cc_out),
    .cc_fwd       (cc_fwd),
    .cc_ready     (cc_ready),
    .br_stall     (br_stall),
    .pending      (pending),
    .cc_err       (cc_err)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; the expected view of that cycle is queued.
  task automatic applyStimulus(input logic rst, input logic cl, input logic ld,
                               input logic [15:0] wb, input logic fl, input logic [1:0] sq,
                               input logic br, input bit chk,
                               input logic [2:0] eOut, input logic [2:0] eFwd,
                               input logic eRdy, input logic eStall,
                               input logic [1:0] ePend, input logic eErr);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; cc_claim = cl; load_cc = ld; wb_data = wb;
    flush = fl; flush_squash = sq; br_req = br;
    e.chk = chk; e.idx = vecNum; e.out = eOut; e.fwd = eFwd; e.rdy = eRdy;
    e.stall = eStall; e.pend = ePend; e.err = eErr;
    expQ.push_back(e);
    vecNum++;
  endtask

  task automatic checkOutput(input exp_t e);
    checks += 6;
    if (cc_out !== e.out) begin
      failures++; $display("[TB] FAIL v%0d cc_out got %b want %b", e.idx, cc_out, e.out);
    end
    if (cc_fwd !== e.fwd) begin
      failures++; $display("[TB] FAIL v%0d cc_fwd got %b want %b", e.idx, cc_fwd, e.fwd);
    end
    if (cc_ready !== e.rdy) begin
      failures++; $display("[TB] FAIL v%0d cc_ready got %b want %b", e.idx, cc_ready, e.rdy);
    end
    if (br_stall !== e.stall) begin
      failures++; $display("[TB] FAIL v%0d br_stall got %b want %b", e.idx, br_stall, e.stall);
    end
    if (pending !== e.pend) begin
      failures++; $display("[TB] FAIL v%0d pending got %0d want %0d", e.idx, pending, e.pend);
    end
    if (cc_err !== e.err) begin
      failures++; $display("[TB] FAIL v%0d cc_err got %b want %b", e.idx, cc_err, e.err);
    end
  endtask

  // Monitor: consume one expectation per cycle, mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.chk) checkOutput(e);
    end
  end

  initial begin
    reset = 1'b1; cc_claim = 1'b0; load_cc = 1'b0; wb_data = 16'h0;
    flush = 1'b0; flush_squash = 2'd0; br_req = 1'b0;

    //            rst cl ld wb        fl sq br chk  out     fwd     rdy stl pnd err
    // Reset held two cycles with a load pending
    applyStimulus(1, 0, 1, 16'h8000, 0, 0, 0, 0, 3'b010, 3'b100, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 16'h8000, 0, 0, 0, 1, 3'b010, 3'b100, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 0);
    // Generation with unclaimed loads (first one underflows)
    applyStimulus(0, 0, 1, 16'hFFFF, 0, 0, 0, 1, 3'b010, 3'b100, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b010, 1, 0, 0, 1);
    applyStimulus(0, 0, 1, 16'h0001, 0, 0, 0, 1, 3'b010, 3'b001, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b001, 1, 0, 0, 1);
    // Stall and bypass
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 1, 3'b010, 3'b010, 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 16'h0000, 0, 0, 1, 1, 3'b010, 3'b010, 0, 1, 2, 0);
    applyStimulus(0, 0, 1, 16'h8000, 0, 0, 1, 1, 3'b010, 3'b100, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 1, 3'b100, 3'b100, 1, 0, 0, 0);
    // Simultaneous claim and load
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 16'h0005, 0, 0, 1, 1, 3'b100, 3'b001, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 1, 1, 3'b001, 3'b001, 0, 1, 1, 0);
    // Flush squashing two of three, then three of three
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b001, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b001, 3'b001, 0, 0, 2, 0);
    applyStimulus(0, 1, 1, 16'hFFFF, 1, 2, 0, 1, 3'b001, 3'b100, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b100, 3'b100, 0, 0, 2, 0);
    applyStimulus(0, 1, 1, 16'h0000, 1, 3, 0, 1, 3'b100, 3'b010, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 1);
    // Saturation on the fourth claim, sticky until reset
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 2, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 1, 1, 3'b010, 3'b010, 0, 1, 3, 1);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 3, 1);
    applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 0, 0, 3, 1);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0, 1, 3'b010, 3'b010, 1, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain %0d expectations left, want 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
